// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg
// Shared types and constants for the motor PWM speed/auto-off controller:
// speed state encoding, default duty/timing values, the timer-setting to
// seconds table and the speed-advance helper.
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } speed_state_e;

    localparam int CNT_W = 10;
    localparam int SEC_W = 6;

    localparam int DEF_PERIOD_MAX      = 999;
    localparam int DEF_DUTY_LOW        = 250;
    localparam int DEF_DUTY_MID        = 500;
    localparam int DEF_DUTY_HIGH       = 750;
    localparam int DEF_PERIODS_PER_SEC = 1000;
    localparam int DEF_DUTY_STEP       = 50;

    // Timer setting index -> seconds (index 0 means "timer off").
    function automatic logic [SEC_W-1:0] timer_setting_sec(input logic [1:0] idx);
        logic [SEC_W-1:0] sec;
        case (idx)
            2'd0:    sec = 6'd0;
            2'd1:    sec = 6'd10;
            2'd2:    sec = 6'd30;
            default: sec = 6'd60;
        endcase
        return sec;
    endfunction

    function automatic speed_state_e next_speed(input speed_state_e s);
        speed_state_e n;
        case (s)
            ST_STOP: n = ST_LOW;
            ST_LOW:  n = ST_MID;
            ST_MID:  n = ST_HIGH;
            default: n = ST_STOP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pwm_sec_timer.sv
// pwm_sec_timer
// Auto-off countdown. A prescaler counts PWM period boundaries; every
// PERIODS_PER_SEC boundaries the seconds counter decrements. The step from
// 1 to 0 raises o_expire for that cycle and drops o_active on the same edge.
//
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_p_end          period boundary pulse
//   i_run            speed state is not STOP (countdown allowed)
//   i_load           load i_load_sec and clear the prescaler
//   i_load_sec       seconds for the new setting
//   i_clear          release the timer (overrides load)
//   o_sec            remaining seconds, 0 when inactive
//   o_active         countdown running
//   o_expire         combinational, high in the cycle whose edge reaches 0
module pwm_sec_timer
    import motor_pwm_pkg::*;
#(
    parameter int PERIODS_PER_SEC = DEF_PERIODS_PER_SEC
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_p_end,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [SEC_W-1:0] i_load_sec,
    input  logic             i_clear,
    output logic [SEC_W-1:0] o_sec,
    output logic             o_active,
    output logic             o_expire
);

    localparam int PRESC_W = (PERIODS_PER_SEC > 1) ? $clog2(PERIODS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PERIODS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               active_q, active_d;
    logic               sec_tick;

    // Kept independent of i_clear/i_load: the controller derives i_clear
    // from o_expire, so this path must not loop back through them.
    assign sec_tick = active_q && i_run && i_p_end && (presc_q == PRESC_LAST);
    assign o_expire = sec_tick && (sec_q == 6'd1);

    always_comb begin
        presc_d  = presc_q;
        sec_d    = sec_q;
        active_d = active_q;
        if (i_clear) begin
            presc_d  = '0;
            sec_d    = '0;
            active_d = 1'b0;
        end else if (i_load) begin
            presc_d  = '0;
            sec_d    = i_load_sec;
            active_d = (i_load_sec != '0);
        end else if (active_q && i_run && i_p_end) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                sec_d   = sec_q - 6'd1;
                if (sec_q == 6'd1) begin
                    active_d = 1'b0;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_q  <= '0;
            sec_q    <= '0;
            active_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            active_q <= active_d;
        end
    end

    assign o_sec    = sec_q;
    assign o_active = active_q;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl
// Speed/auto-off controller for the motor PWM path. Compares the external
// free-running period counter against the active duty to drive o_pwm; duty
// only changes at the period boundary so no runt pulses are produced.
// Build option: define SOFT_START_EN to ramp the duty by DUTY_STEP per
// period instead of jumping to the target.
//
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_counter         period counter, 0..PERIOD_MAX
//   i_btn_speed       pulse: advance STOP->LOW->MID->HIGH->STOP
//   i_btn_timer       pulse: advance timer setting 0/10/30/60 s
//   i_btn_stop        pulse: force STOP
//   o_pwm             registered motor drive
//   o_state           speed state
//   o_led             one-hot of o_state
//   o_timer_sec       remaining seconds
//   o_timer_active    countdown running
//
// state   | meaning
// --------+------------------------------------------
// ST_STOP | motor off, duty target 0, timer released
// ST_LOW  | duty target DUTY_LOW
// ST_MID  | duty target DUTY_MID
// ST_HIGH | duty target DUTY_HIGH
module motor_pwm_ctrl
    import motor_pwm_pkg::*;
#(
    parameter int PERIOD_MAX      = DEF_PERIOD_MAX,
    parameter int DUTY_LOW        = DEF_DUTY_LOW,
    parameter int DUTY_MID        = DEF_DUTY_MID,
    parameter int DUTY_HIGH       = DEF_DUTY_HIGH,
    parameter int PERIODS_PER_SEC = DEF_PERIODS_PER_SEC,
    parameter int DUTY_STEP       = DEF_DUTY_STEP
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_counter,
    input  logic             i_btn_speed,
    input  logic             i_btn_timer,
    input  logic             i_btn_stop,
    output logic             o_pwm,
    output logic [1:0]       o_state,
    output logic [3:0]       o_led,
    output logic [SEC_W-1:0] o_timer_sec,
    output logic             o_timer_active
);

    speed_state_e     state_q, state_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [1:0]       tidx_q, tidx_d;
    logic             pwm_q, pwm_d;

    logic             p_end;
    logic             timer_load;
    logic             timer_clear;
    logic             timer_expire;
    logic [SEC_W-1:0] load_sec;
    logic [CNT_W-1:0] target;

    assign p_end = (i_counter == CNT_W'(PERIOD_MAX));

    always_comb begin
        state_d = state_q;
        if (i_btn_stop) begin
            state_d = ST_STOP;
        end else if (timer_expire) begin
            state_d = ST_STOP;
        end else if (i_btn_speed) begin
            state_d = next_speed(state_q);
        end
    end

    // Timer presses are judged against the current state, so a press in
    // STOP is ignored even when a speed press leaves STOP in the same cycle.
    assign timer_load  = i_btn_timer && (state_q != ST_STOP);
    assign timer_clear = (state_d == ST_STOP);
    assign load_sec    = timer_setting_sec(tidx_q + 2'd1);

    always_comb begin
        tidx_d = tidx_q;
        if (timer_clear) begin
            tidx_d = 2'd0;
        end else if (timer_load) begin
            tidx_d = tidx_q + 2'd1;
        end
    end

    // Target follows the state that holds for the coming period, so a stop
    // or expiry on the boundary edge already silences the next period.
    always_comb begin
        case (state_d)
            ST_LOW:  target = CNT_W'(DUTY_LOW);
            ST_MID:  target = CNT_W'(DUTY_MID);
            ST_HIGH: target = CNT_W'(DUTY_HIGH);
            default: target = '0;
        endcase
    end

`ifdef SOFT_START_EN
    logic [CNT_W:0] duty_up;
    logic [CNT_W:0] target_plus_step;

    assign duty_up          = {1'b0, duty_q} + (CNT_W+1)'(DUTY_STEP);
    assign target_plus_step = {1'b0, target} + (CNT_W+1)'(DUTY_STEP);

    always_comb begin
        duty_d = duty_q;
        if (p_end) begin
            if (target == '0) begin
                duty_d = '0;
            end else if (duty_q < target) begin
                duty_d = (duty_up >= {1'b0, target}) ? target : duty_up[CNT_W-1:0];
            end else if (duty_q > target) begin
                duty_d = ({1'b0, duty_q} <= target_plus_step) ? target
                                                              : duty_q - CNT_W'(DUTY_STEP);
            end
        end
    end
`else
    always_comb begin
        duty_d = duty_q;
        if (p_end) begin
            duty_d = target;
        end
    end
`endif

    assign pwm_d = (i_counter < duty_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_STOP;
            duty_q  <= '0;
            tidx_q  <= 2'd0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tidx_q  <= tidx_d;
            pwm_q   <= pwm_d;
        end
    end

    pwm_sec_timer #(
        .PERIODS_PER_SEC(PERIODS_PER_SEC)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_p_end    (p_end),
        .i_run      (state_q != ST_STOP),
        .i_load     (timer_load),
        .i_load_sec (load_sec),
        .i_clear    (timer_clear),
        .o_sec      (o_timer_sec),
        .o_active   (o_timer_active),
        .o_expire   (timer_expire)
    );

    assign o_pwm   = pwm_q;
    assign o_state = state_q;
    assign o_led   = 4'(4'b0001 << state_q);

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
module tb_motor_pwm_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [9:0] i_counter;
    logic       i_btn_speed;
    logic       i_btn_timer;
    logic       i_btn_stop;
    logic       o_pwm;
    logic [1:0] o_state;
    logic [3:0] o_led;
    logic [5:0] o_timer_sec;
    logic       o_timer_active;

    int checks = 0;
    int errors = 0;

    motor_pwm_ctrl #(
        .PERIODS_PER_SEC(2)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_counter      (i_counter),
        .i_btn_speed    (i_btn_speed),
        .i_btn_timer    (i_btn_timer),
        .i_btn_stop     (i_btn_stop),
        .o_pwm          (o_pwm),
        .o_state        (o_state),
        .o_led          (o_led),
        .o_timer_sec    (o_timer_sec),
        .o_timer_active (o_timer_active)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: the edge samples the current i_counter/buttons, then the
    // counter advances and the button pulses are released.
    task automatic step();
        @(posedge i_clk);
        #1;
        i_btn_speed = 1'b0;
        i_btn_timer = 1'b0;
        i_btn_stop  = 1'b0;
        i_counter   = (i_counter == 10'd999) ? 10'd0 : i_counter + 10'd1;
    endtask

    task automatic run_to(input int n);
        for (int g = 0; g < 2000 && i_counter != 10'(n); g++) step();
        check("run_to", i_counter, n);
    endtask

    task automatic run_pends(input int n);
        int seen;
        seen = 0;
        for (int g = 0; g < (n + 1) * 1000 && seen < n; g++) begin
            if (i_counter == 10'd999) seen++;
            step();
        end
        check("pend_count", seen, n);
    endtask

    // Starts at counter 0; runs one full period and counts o_pwm high
    // cycles. press_at >= 0 injects a speed (or stop) pulse at that count.
    task automatic measure_period(input int press_at, input bit use_stop,
                                  output int hi, output int first_low);
        hi = 0;
        first_low = -1;
        for (int k = 0; k < 1000; k++) begin
            if (k == press_at) begin
                if (use_stop) i_btn_stop = 1'b1;
                else          i_btn_speed = 1'b1;
            end
            step();
            if (o_pwm) hi++;
            else if (first_low < 0) first_low = k;
        end
    endtask

    initial begin
        int hi;
        int fl;
        i_reset     = 1'b1;
        i_counter   = 10'd0;
        i_btn_speed = 1'b0;
        i_btn_timer = 1'b0;
        i_btn_stop  = 1'b0;
        #12;
        check("rst_pwm", o_pwm, 0);
        check("rst_state", o_state, 0);
        check("rst_led", o_led, 4'b0001);
        check("rst_sec", o_timer_sec, 0);
        check("rst_active", o_timer_active, 0);
        @(negedge i_clk);
        i_reset = 1'b0;

`ifndef SOFT_START_EN
        // Speed press mid-period: no pwm in this period, 25% in the next.
        run_to(300);
        i_btn_speed = 1'b1;
        step();
        check("s1_state", o_state, 1);
        check("s1_led", o_led, 4'b0010);
        hi = 0;
        for (int g = 0; g < 1000 && i_counter != 10'd0; g++) begin
            step();
            if (o_pwm) hi++;
        end
        check("s1_cur_period_hi", hi, 0);
        measure_period(-1, 1'b0, hi, fl);
        check("s1_low_hi", hi, 250);
        check("s1_low_first_low", fl, 250);

        // LOW->MID at count 0: current period stays 25%.
        measure_period(0, 1'b0, hi, fl);
        check("s2_state_mid", o_state, 2);
        check("s2_low_kept", hi, 250);
        // MID->HIGH at count 600: this period 50%, next 75%.
        measure_period(600, 1'b0, hi, fl);
        check("s2_state_high", o_state, 3);
        check("s2_mid_hi", hi, 500);
        measure_period(-1, 1'b0, hi, fl);
        check("s2_high_hi", hi, 750);
        check("s2_high_first_low", fl, 750);

        // 10 s timer in LOW with 2 periods per second; expiry + speed -> STOP.
        i_btn_stop = 1'b1;
        step();
        check("s3_stop", o_state, 0);
        i_btn_speed = 1'b1;
        step();
        check("s3_low", o_state, 1);
        i_btn_timer = 1'b1;
        step();
        check("s3_sec10", o_timer_sec, 10);
        check("s3_active", o_timer_active, 1);
        check("s3_state_kept", o_state, 1);
        run_pends(2);
        check("s3_sec9", o_timer_sec, 9);
        run_pends(17);
        check("s3_sec1", o_timer_sec, 1);
        check("s3_still_low", o_state, 1);
        run_to(999);
        i_btn_speed = 1'b1;
        step();
        check("s3_exp_state", o_state, 0);
        check("s3_exp_sec", o_timer_sec, 0);
        check("s3_exp_active", o_timer_active, 0);
        check("s3_exp_led", o_led, 4'b0001);
        measure_period(-1, 1'b0, hi, fl);
        check("s3_after_exp_hi", hi, 0);

        // Timer press in STOP ignored, also alongside a speed press.
        i_btn_timer = 1'b1;
        step();
        check("s4_stop_tmr_sec", o_timer_sec, 0);
        check("s4_stop_tmr_act", o_timer_active, 0);
        i_btn_timer = 1'b1;
        i_btn_speed = 1'b1;
        step();
        check("s4_spd_tmr_state", o_state, 1);
        check("s4_spd_tmr_sec", o_timer_sec, 0);
        // Timer + speed in LOW: both applied.
        i_btn_timer = 1'b1;
        i_btn_speed = 1'b1;
        step();
        check("s4_both_state", o_state, 2);
        check("s4_both_sec", o_timer_sec, 10);
        i_btn_speed = 1'b1;
        step();
        i_btn_timer = 1'b1;
        step();
        check("s4_high_state", o_state, 3);
        check("s4_sec30", o_timer_sec, 30);
        check("s4_active30", o_timer_active, 1);
        // Stop + speed together: STOP, timer released.
        i_btn_stop  = 1'b1;
        i_btn_speed = 1'b1;
        step();
        check("s4_ss_state", o_state, 0);
        check("s4_ss_sec", o_timer_sec, 0);
        check("s4_ss_active", o_timer_active, 0);
        // Index restarted from 0: next press selects 10 s.
        i_btn_speed = 1'b1;
        step();
        i_btn_timer = 1'b1;
        step();
        check("s4_idx_reset_sec", o_timer_sec, 10);

        // Reset mid-period in HIGH.
        i_btn_speed = 1'b1;
        step();
        i_btn_speed = 1'b1;
        step();
        check("s5_high", o_state, 3);
        run_to(999);
        step();
        run_to(100);
        check("s5_pwm_hi", o_pwm, 1);
        #2;
        i_reset = 1'b1;
        #1;
        check("s5_pwm_async", o_pwm, 0);
        check("s5_state", o_state, 0);
        check("s5_led", o_led, 4'b0001);
        check("s5_sec", o_timer_sec, 0);
        check("s5_active", o_timer_active, 0);
        @(negedge i_clk);
        i_reset   = 1'b0;
        i_counter = 10'd0;
        measure_period(-1, 1'b0, hi, fl);
        check("s5_post_rst_hi", hi, 0);
`else
        // Soft start STOP->HIGH: 50, 100, 150, then stop mid-ramp -> 0.
        for (int k = 0; k < 3; k++) begin
            i_btn_speed = 1'b1;
            step();
        end
        check("s6_high", o_state, 3);
        run_to(0);
        measure_period(-1, 1'b0, hi, fl);
        check("s6_ramp50", hi, 50);
        measure_period(-1, 1'b0, hi, fl);
        check("s6_ramp100", hi, 100);
        measure_period(-1, 1'b0, hi, fl);
        check("s6_ramp150", hi, 150);
        measure_period(500, 1'b1, hi, fl);
        check("s6_stop_state", o_state, 0);
        check("s6_ramp200", hi, 200);
        measure_period(-1, 1'b0, hi, fl);
        check("s6_after_stop", hi, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
Speed/auto-off controller for the motor PWM path. Consumes the free-running 10-bit period counter (0..999, one PWM period per wrap) and generates the PWM output from the selected duty. A 4-state speed FSM is driven by debounced button pulses, and a countdown timer forces STOP on expiry. Duty changes take effect only at a period boundary, so the output never carries a runt pulse.

Parameters:
PERIOD_MAX, 999, last count value of the period counter; the boundary pulse fires at this value
DUTY_LOW, 250, compare value for LOW speed (25%)
DUTY_MID, 500, compare value for MID speed (50%)
DUTY_HIGH, 750, compare value for HIGH speed (75%)
PERIODS_PER_SEC, 1000, PWM periods per timer second
DUTY_STEP, 50, ramp increment per period (SOFT_START_EN only)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_counter  in  10  period counter value, 0..PERIOD_MAX
i_btn_speed  in  1  one-cycle pulse; advance speed
i_btn_timer  in  1  one-cycle pulse; advance timer setting
i_btn_stop  in  1  one-cycle pulse; force STOP
o_pwm  out  1  motor drive
o_state  out  2  0=STOP, 1=LOW, 2=MID, 3=HIGH
o_led  out  4  one-hot of o_state; bit n set when o_state==n
o_timer_sec  out  6  remaining seconds; 0 when the timer is inactive
o_timer_active  out  1  countdown running

Behaviour:
- Reset (async, i_reset, active-high) sets: state STOP; active duty 0; o_pwm=0; o_led=4'b0001; timer setting index 0; o_timer_sec=0; o_timer_active=0; second prescaler 0.
- Period boundary: p_end is 1 in any cycle where i_counter==PERIOD_MAX.
- PWM output: o_pwm is registered. o_pwm <= (i_counter < duty_active). It is 0 whenever duty_active==0.
- Duty update: duty_active loads the target duty of the current state only in a p_end cycle. The new duty applies from count 0 of the next period. Target duty per state: STOP=0, LOW=DUTY_LOW, MID=DUTY_MID, HIGH=DUTY_HIGH.
- Speed FSM transitions:
  - Priority order: stop > timer expiry > speed.
  - i_btn_stop: go to STOP.
  - Expiry: go to STOP.
  - i_btn_speed: STOP->LOW->MID->HIGH->STOP.
  - o_state and o_led update on the clock edge after the press.
- Timer setting: i_btn_timer cycles the setting index 0->1->2->3->0, which maps to 0/10/30/60 s.
  - Each press loads o_timer_sec with the new setting's seconds and clears the prescaler.
  - o_timer_active = 1 when the new setting is nonzero.
  - A press in STOP is ignored: no change to index or timer.
- Countdown: while o_timer_active=1 and state != STOP:
  - The prescaler counts p_end pulses from 0 to PERIODS_PER_SEC-1, then wraps and decrements o_timer_sec.
  - A decrement from 1 to 0 is expiry: state becomes STOP, o_timer_active=0, setting index=0, all on that same edge.
- Timer release on STOP: entering STOP by any cause clears the timer (index 0, sec 0, active 0).
- Simultaneous presses in one cycle:
  - stop + speed -> STOP.
  - expiry + speed -> STOP.
  - timer + speed -> both applied.
  - stop + timer -> STOP with the timer cleared.
- Mid-period reset: o_pwm drops asynchronously and immediately.

Optional Feature:
SOFT_START_EN
- Defined: at each p_end, duty_active moves toward the target by at most DUTY_STEP, rising or falling. The exception is a STOP target, which sets duty_active to 0 at once.
  - Example: STOP->LOW with default parameters gives duty 50,100,150,200,250 over five periods.
- Undefined: duty_active jumps to the target at the next p_end.

Decomposition:
- Package motor_pwm_pkg holds:
  - the state encoding constants (ST_STOP, ST_LOW, ST_MID, ST_HIGH);
  - default duty constants;
  - the timer-setting-to-seconds table (0,10,30,60).
- One sub-module, pwm_sec_timer:
  - contains the prescaler, the seconds down-counter, load on setting change, clear on STOP, and a one-cycle o_expire pulse;
  - the controller FSM instantiates it.

Test Plan:
All scenarios use PERIODS_PER_SEC=2 and drive i_counter from the standard 0..999 counter.
1. Reset, then press speed once -> o_state=1, o_led=0010. o_pwm high for counts 0..249 of the next period, low for 250..999. o_pwm stays 0 in the current period.
2. Press speed at i_counter=600 while in MID -> the current period completes at 50% duty; the next period is 75%. No pulse shorter than 500 or longer than 750 cycles.
3. In LOW, press timer once (10 s) -> o_timer_sec=10 and active. After 20 p_end pulses: state STOP, o_timer_sec=0, active=0, o_pwm=0 from the next period.
4. Press timer in STOP -> no change. In HIGH, press timer twice -> o_timer_sec=30. Press stop and speed in the same cycle -> state STOP and timer cleared.
5. Assert i_reset at i_counter=100 in HIGH -> o_pwm=0 the same cycle, all outputs at reset values.
6. With SOFT_START_EN defined, STOP->HIGH -> per-period duty 50,100,...,750 over 15 periods. A stop press mid-ramp gives duty 0 at the next p_end.
